// File: rtl/door_plant_model.sv
// Door plant model: turns motor drive (ml/mr) into a door position with end-stop
// sensors, and latches a fault on conflicting drive or sustained end-stop overdrive.
module door_plant_model #(
  parameter int unsigned STEP_DIV = 2000,
  parameter int unsigned POS_MAX  = 200,
  parameter int unsigned OVR_CYC  = 4000
) (
  input  logic       clk2m,
  input  logic       rst,
  input  logic       ml,
  input  logic       mr,
  output logic       sense_up,
  output logic       sense_down,
  output logic [7:0] pos,
  output logic       moving,
  output logic       fault
);

  localparam int unsigned PW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned OW = (OVR_CYC > 1) ? $clog2(OVR_CYC + 1) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [OW-1:0] OVR_LAST   = OW'(OVR_CYC - 1);
  localparam logic [7:0]    POS_TOP    = 8'(POS_MAX);
  localparam logic [7:0]    POS_BELOW  = 8'(POS_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      pos_q, pos_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [OW-1:0]   ovr_q, ovr_d;
  logic            up_ok, dn_ok;

  always_ff @(posedge clk2m or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pos_q   <= '0;
      presc_q <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      presc_q <= presc_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    presc_d = presc_q;
    ovr_d   = ovr_q;
    up_ok   = (pos_q != POS_TOP);
    dn_ok   = (pos_q != 8'd0);

    if (state_q != FAULT && ml && mr) begin
      state_d = FAULT;
      presc_d = '0;
      ovr_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          presc_d = '0;
          ovr_d   = '0;
          // The entry cycle already counts toward the first step.
          if (ml) begin
            if (up_ok) begin
              state_d = UP;
              presc_d = PW'(1);
            end else begin
              ovr_d = ovr_q + OW'(1);
              if (ovr_q == OVR_LAST) state_d = FAULT;
            end
          end else if (mr) begin
            if (dn_ok) begin
              state_d = DOWN;
              presc_d = PW'(1);
            end else begin
              ovr_d = ovr_q + OW'(1);
              if (ovr_q == OVR_LAST) state_d = FAULT;
            end
          end
        end
        UP: begin
          ovr_d = '0;
          if (ml) begin
            if (presc_q == PRESC_LAST) begin
              presc_d = '0;
              pos_d   = pos_q + 8'd1;
              if (pos_q == POS_BELOW) state_d = IDLE;
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end else begin
            presc_d = '0;
            state_d = (mr && dn_ok) ? DOWN : IDLE;
          end
        end
        DOWN: begin
          ovr_d = '0;
          if (mr) begin
            if (presc_q == PRESC_LAST) begin
              presc_d = '0;
              pos_d   = pos_q - 8'd1;
              if (pos_q == 8'd1) state_d = IDLE;
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end else begin
            presc_d = '0;
            state_d = (ml && up_ok) ? UP : IDLE;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign pos        = pos_q;
  assign sense_up   = (pos_q == POS_TOP);
  assign sense_down = (pos_q == 8'd0);
  assign moving     = (state_q == UP) || (state_q == DOWN);
  assign fault      = (state_q == FAULT);

endmodule

// File: tb/tb_door_plant_model.sv
// Bench for door_plant_model: directed scenarios plus randomized motor drive,
// compared every cycle against a position/direction reference model.
module tb_door_plant_model;

  localparam int SD = 4;
  localparam int PM = 5;
  localparam int OC = 6;

  logic       clk2m = 1'b0;
  logic       rst   = 1'b1;
  logic       ml    = 1'b0;
  logic       mr    = 1'b0;
  logic       sense_up, sense_down, moving, fault;
  logic [7:0] pos;

  int total = 0;
  int bad   = 0;

  // reference model: position, travel direction (+1/-1/0), fault latch,
  // cycles into the current step, cycles spent pushing an end stop
  int m_pos, m_dir, m_ph, m_push;
  bit m_flt;

  door_plant_model #(.STEP_DIV(SD), .POS_MAX(PM), .OVR_CYC(OC)) dut (
    .clk2m(clk2m), .rst(rst), .ml(ml), .mr(mr),
    .sense_up(sense_up), .sense_down(sense_down),
    .pos(pos), .moving(moving), .fault(fault)
  );

  always #250 clk2m = ~clk2m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit can_go(input int dir);
    return (dir > 0) ? (m_pos < PM) : (m_pos > 0);
  endfunction

  task automatic model_reset();
    m_pos = 0; m_dir = 0; m_ph = 0; m_push = 0; m_flt = 1'b0;
  endtask

  task automatic model_edge(input bit l, input bit r);
    int want;
    if (m_flt) return;
    if (l && r) begin
      m_flt = 1'b1; m_dir = 0;
      return;
    end
    want = l ? 1 : (r ? -1 : 0);
    if (want == 0) begin
      m_dir = 0; m_ph = 0; m_push = 0;
    end else if (m_dir == 0) begin
      if (can_go(want)) begin
        m_dir = want; m_ph = 1; m_push = 0;
      end else begin
        m_push++;
        if (m_push == OC) m_flt = 1'b1;
      end
    end else if (want != m_dir) begin
      m_push = 0; m_ph = 0;
      m_dir = can_go(want) ? want : 0;
    end else begin
      m_push = 0;
      m_ph++;
      if (m_ph == SD) begin
        m_ph = 0;
        m_pos += m_dir;
        if (m_pos == 0 || m_pos == PM) m_dir = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pos"}, 32'(pos), 32'(m_pos));
    chk({tag, ".flags"}, {28'd0, sense_up, sense_down, moving, fault},
        {28'd0, m_pos == PM, m_pos == 0, (m_dir != 0) && !m_flt, m_flt});
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk2m);
      if (!rst) model_edge(ml, mr);
      #1;
      check_model("cyc");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_model("rst");
    @(posedge clk2m);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int kind, len;
    model_reset();

    // reset and open
    #1;
    chk("reset_flags", {28'd0, sense_up, sense_down, moving, fault}, 32'b0100);
    chk("reset_pos", 32'(pos), 32'd0);
    @(posedge clk2m); #1; rst = 1'b0;
    ml = 1'b1;
    step(3);
    chk("open_no_step", 32'(pos), 32'd0);
    chk("open_moving", 32'(moving), 32'd1);
    step(1);
    chk("open_step1", 32'(pos), 32'd1);
    chk("open_sdown_fall", 32'(sense_down), 32'd0);
    step(16);
    chk("open_top", 32'(pos), 32'd5);
    chk("open_sup", 32'(sense_up), 32'd1);
    chk("open_stop", 32'(moving), 32'd0);
    ml = 1'b0;
    step(2);

    // close
    mr = 1'b1;
    step(4);
    chk("close_step1", 32'(pos), 32'd4);
    chk("close_sup_fall", 32'(sense_up), 32'd0);
    step(16);
    chk("close_bottom", 32'(pos), 32'd0);
    chk("close_sdown", 32'(sense_down), 32'd1);
    chk("close_stop", 32'(moving), 32'd0);
    mr = 1'b0;
    step(2);

    // partial step, then reversal
    ml = 1'b1; step(3);
    ml = 1'b0; step(1);
    chk("partial_pos", 32'(pos), 32'd0);
    chk("partial_idle", 32'(moving), 32'd0);
    ml = 1'b1; step(6);
    chk("rev_pre", 32'(pos), 32'd1);
    ml = 1'b0; mr = 1'b1;
    step(1);
    chk("rev_moving", 32'(moving), 32'd1);
    step(3);
    chk("rev_hold", 32'(pos), 32'd1);
    step(1);
    chk("rev_dec", 32'(pos), 32'd0);
    mr = 1'b0; step(1);

    // conflicting inputs at pos=2
    ml = 1'b1; step(8);
    chk("conf_pre", 32'(pos), 32'd2);
    mr = 1'b1; step(1);
    chk("conf_fault", 32'(fault), 32'd1);
    chk("conf_pos", 32'(pos), 32'd2);
    chk("conf_moving", 32'(moving), 32'd0);
    ml = 1'b0; mr = 1'b0; step(5);
    chk("conf_latched", 32'(fault), 32'd1);
    ml = 1'b1; step(3);
    chk("conf_frozen", 32'(pos), 32'd2);
    ml = 1'b0;
    do_reset();

    // overdrive at the top end stop
    ml = 1'b1; step(20);
    chk("ovr_top", 32'(pos), 32'd5);
    step(5);
    chk("ovr_5cyc", 32'(fault), 32'd0);
    ml = 1'b0; step(1);
    chk("ovr_drop", 32'(fault), 32'd0);
    ml = 1'b1; step(5);
    chk("ovr_again5", 32'(fault), 32'd0);
    step(1);
    chk("ovr_fault", 32'(fault), 32'd1);
    chk("ovr_pos", 32'(pos), 32'd5);
    ml = 1'b0;
    do_reset();

    // reset during travel, between clock edges
    ml = 1'b1; step(13);
    chk("mid_pre", 32'(pos), 32'd3);
    #100;
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_pos", 32'(pos), 32'd0);
    chk("mid_flags", {28'd0, sense_up, sense_down, moving, fault}, 32'b0100);
    ml = 1'b0;
    @(posedge clk2m); #1; rst = 1'b0;
    step(2);

    // randomized drive
    for (int seg = 0; seg < 600; seg++) begin
      kind = $urandom_range(0, 99);
      len  = $urandom_range(1, 12);
      if (kind < 4) begin
        ml = 1'b0; mr = 1'b0;
        do_reset();
      end else begin
        ml = (kind < 9) || (kind >= 9 && kind < 45);
        mr = (kind < 9) || (kind >= 45 && kind < 80);
        if (kind >= 80) begin ml = 1'b0; mr = 1'b0; end
        step(len);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
